yin_tau_search: RTL and testbench

- Controller and consumer stage directly downstream of the squared-difference accumulator in the YIN pitch path.
- Sweeps lag tau from MIN_TAU to MAX_TAU. For each lag it restarts the difference stage, collects d(tau), and updates the cumulative sum.
- Applies the cumulative-mean-normalised threshold test d'(tau) = d(tau)*tau/S(tau) < THRESH, evaluated division-free by cross-multiplication.
- Reports the selected period tau to the pitch-output stage.

---
 rtl/yin_tau_search.sv | 141 ++++++++++++++
 tb/tb_yin_tau_search.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/yin_tau_search.sv
// YIN lag sweep: restarts the difference stage per lag, accumulates S(tau), and applies the division-free threshold test.
// Each lag costs LOAD + WAIT + EVAL cycles; WAIT waits for diff_ready with no timeout. YIN_LOCAL_MIN_EN extends the sweep to the local minimum.
module yin_tau_search #(
    parameter int INTERMEDIATE_DATA_WIDTH = 64,
    parameter int MIN_TAU                 = 1,
    parameter int MAX_TAU                 = 40,
    parameter int FRAC_BITS               = 8,
    parameter int THRESH                  = 26
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic [5:0]                         diff_tau,
    output logic                               diff_reset,
    input  logic                               diff_ready,
    input  logic [INTERMEDIATE_DATA_WIDTH-1:0] diff_value,
    output logic                               busy,
    output logic                               done,
    output logic                               found,
    output logic [5:0]                         best_tau
);

    localparam int W  = INTERMEDIATE_DATA_WIDTH;
    localparam int SW = W + 6;
    localparam int CW = SW + FRAC_BITS + 1;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, EVAL, FINISH} state_t;

    state_t         state, state_nxt;
    logic [5:0]     cur_tau;
    logic [W-1:0]   d_reg;
    logic [SW-1:0]  s_acc;
    logic [SW-1:0]  s_new;
    logic [SW-1:0]  num_new;
    logic [CW-1:0]  lhs;
    logic [CW-1:0]  rhs;
    logic           cand;
    logic           last_tau;
    logic           adopt;
    logic           stop;

`ifdef YIN_LOCAL_MIN_EN
    localparam int PW = 2 * SW;
    logic [SW-1:0]  num_b;
    logic [SW-1:0]  den_b;
    logic [PW-1:0]  cross_new;
    logic [PW-1:0]  cross_b;
    logic           improves;
`endif

    // d*tau*2^F < THRESH*S is d'(tau) < THRESH/2^F without a divider
    always_comb begin
        s_new    = s_acc + SW'(d_reg);
        num_new  = SW'(d_reg) * SW'(cur_tau);
        lhs      = CW'(num_new) << FRAC_BITS;
        rhs      = CW'(THRESH) * CW'(s_new);
        cand     = lhs < rhs;
        last_tau = (cur_tau == 6'(MAX_TAU));
`ifdef YIN_LOCAL_MIN_EN
        cross_new = PW'(num_new) * PW'(den_b);
        cross_b   = PW'(num_b) * PW'(s_new);
        improves  = cross_new < cross_b;
        // found doubles as "a best fraction is stored"
        if (found) begin
            adopt = improves;
            stop  = !improves || last_tau;
        end else begin
            adopt = cand;
            stop  = last_tau;
        end
`else
        adopt = cand;
        stop  = cand || last_tau;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = WAIT;
            WAIT:    if (diff_ready) state_nxt = EVAL;
            EVAL:    state_nxt = stop ? FINISH : LOAD;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_acc    <= '0;
            cur_tau  <= '0;
            d_reg    <= '0;
            found    <= 1'b0;
            best_tau <= '0;
`ifdef YIN_LOCAL_MIN_EN
            num_b    <= '0;
            den_b    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s_acc    <= '0;
                        cur_tau  <= 6'(MIN_TAU);
                        found    <= 1'b0;
                        best_tau <= '0;
                    end
                end
                WAIT: begin
                    if (diff_ready) d_reg <= diff_value;
                end
                EVAL: begin
                    s_acc <= s_new;
                    if (adopt) begin
                        found    <= 1'b1;
                        best_tau <= cur_tau;
`ifdef YIN_LOCAL_MIN_EN
                        num_b    <= num_new;
                        den_b    <= s_new;
`endif
                    end
                    if (!stop) cur_tau <= cur_tau + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // diff_tau tracks cur_tau, which only moves in EVAL, so it is stable through WAIT
    assign diff_tau   = cur_tau;
    assign diff_reset = (state != WAIT);
    assign busy       = (state == LOAD) || (state == WAIT) || (state == EVAL);
    assign done       = (state == FINISH);

endmodule

// File: tb/tb_yin_tau_search.sv
// Bench for yin_tau_search: table-driven difference-stage model (ready 3 cycles after release) and a result scoreboard.
module tb_yin_tau_search;

    localparam int W       = 64;
    localparam int MIN_TAU = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [5:0]    diff_tau;
    logic          diff_reset;
    logic          diff_ready;
    logic [W-1:0]  diff_value;
    logic          busy;
    logic          done;
    logic          found;
    logic [5:0]    best_tau;

    yin_tau_search #(
        .INTERMEDIATE_DATA_WIDTH(W),
        .MIN_TAU(1),
        .MAX_TAU(40),
        .FRAC_BITS(8),
        .THRESH(26)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .diff_tau(diff_tau),
        .diff_reset(diff_reset),
        .diff_ready(diff_ready),
        .diff_value(diff_value),
        .busy(busy),
        .done(done),
        .found(found),
        .best_tau(best_tau)
    );

    always #5 clk = ~clk;

    logic [W-1:0] dtab [0:63];
    logic         model_rdy = 1'b0;
    logic         inject    = 1'b0;
    int           cnt       = 0;

    assign diff_ready = model_rdy | inject;
    assign diff_value = dtab[diff_tau];

    typedef struct {
        int f;
        int t;
        int lags;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests    = 0;
    int   fails    = 0;
    int   loads    = 0;
    int   done_cnt = 0;
    int   seq_err  = 0;
    int   stab_err = 0;
    logic prev_dr  = 1'b1;
    logic [5:0] wait_tau = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [W-1:0] v);
        for (int i = 0; i < 64; i++) dtab[i] = v;
    endtask

    // difference-stage model plus lag/stability/done monitor
    always @(negedge clk) begin
        if (diff_reset) begin
            cnt       = 0;
            model_rdy = 1'b0;
        end else begin
            cnt++;
            model_rdy = (cnt == 3);
        end
        if (!diff_reset && prev_dr) begin
            if (diff_tau != 6'(MIN_TAU + loads)) seq_err++;
            loads++;
            wait_tau = diff_tau;
        end else if (!diff_reset && diff_tau != wait_tau) begin
            stab_err++;
        end
        prev_dr = diff_reset;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("found", 64'(found), 64'(e.f));
                chk("best_tau", 64'(best_tau), 64'(e.t));
                chk("lags", 64'(loads), 64'(e.lags));
                chk("busy_at_done", 64'(busy), 64'd0);
                chk("tau_sequence", 64'(seq_err), 64'd0);
                chk("tau_stable", 64'(stab_err), 64'd0);
            end
        end
    end

    // one frame: start, ready injected during LOAD, stray start mid-sweep
    task automatic run_frame(input string name, input int ef, input int et, input int el);
        int d0;
        sb.push_back('{ef, et, el});
        loads    = 0;
        seq_err  = 0;
        stab_err = 0;
        d0       = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        chk({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        if (done_cnt == d0) sb.delete();
        repeat (3) @(negedge clk);
        chk({name, "_done_pulse_ended"}, 64'(done), 64'd0);
        chk({name, "_found_held"}, 64'(found), 64'(ef));
        chk({name, "_best_held"}, 64'(best_tau), 64'(et));
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        start = 1'b0;
        fill(64'd1000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_diff_tau", 64'(diff_tau), 64'd0);
        chk("rst_diff_reset", 64'(diff_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_best_tau", 64'(best_tau), 64'd0);

        // flat d: d'(tau) stays near 1
        fill(64'd1000);
        run_frame("flat", 0, 0, 40);

        // single dip at tau=10
        fill(64'd1000);
        dtab[10] = 64'd5;
`ifdef YIN_LOCAL_MIN_EN
        run_frame("dip10", 1, 10, 11);
`else
        run_frame("dip10", 1, 10, 10);
`endif

        // deeper point at 11, rise at 12
        dtab[11] = 64'd2;
        dtab[12] = 64'd50;
`ifdef YIN_LOCAL_MIN_EN
        run_frame("localmin", 1, 11, 12);
`else
        run_frame("localmin", 1, 10, 10);
`endif

        fill(64'd0);
        run_frame("silent", 0, 0, 40);

        // abort during WAIT at tau=5
        fill(64'd1000);
        loads    = 0;
        seq_err  = 0;
        stab_err = 0;
        d0       = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 500 && !(diff_reset == 1'b0 && diff_tau == 6'd5); i++) @(negedge clk);
        chk("abort_reached_wait5", 64'(diff_reset == 1'b0 && diff_tau == 6'd5), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_diff_reset", 64'(diff_reset), 64'd1);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_diff_tau", 64'(diff_tau), 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // tau=2 passes only if S still held the aborted sweep's 4000
        fill(64'd1000);
        dtab[2] = 64'd60;
        run_frame("restart", 0, 0, 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
